// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with optional skid entry, flush and stall counter

module pipe_stage_skid_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_stages,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset_stages) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

module pipe_stage_skid #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SKID_EN   = 1,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_stages,
    input  logic             Stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [WIDTH-1:0] main_d;
    logic             main_v;
    logic [WIDTH-1:0] skid_d;
    logic             skid_v;
    logic             accept;
    logic             pop;

    // With the skid entry, in_ready depends only on registered state so the
    // upstream never sees a path from out_ready.
    always_comb begin
        if (SKID_EN != 0) begin
            in_ready = ~Stall & ~skid_v;
        end else begin
            in_ready = ~Stall & (~main_v | out_ready);
        end
    end

    assign accept    = in_valid & in_ready;
    assign pop       = main_v & out_ready & ~Stall;
    assign out_valid = main_v & ~Stall;
    assign out_data  = main_d;
    assign occ       = {1'b0, main_v} + {1'b0, skid_v};

    always_ff @(posedge clk) begin
        if (reset_stages) begin
            main_d <= RESET_VAL;
            skid_d <= RESET_VAL;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; only the valids drop.
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!Stall) begin
            if (SKID_EN != 0) begin
                if (skid_v) begin
                    // Full: in_ready is low, so only the older skid word can move up.
                    if (pop) begin
                        main_d <= skid_d;
                        skid_v <= 1'b0;
                    end
                end else if (main_v) begin
                    if (accept && pop) begin
                        main_d <= in_data;
                    end else if (accept) begin
                        skid_d <= in_data;
                        skid_v <= 1'b1;
                    end else if (pop) begin
                        main_v <= 1'b0;
                    end
                end else if (accept) begin
                    main_d <= in_data;
                    main_v <= 1'b1;
                end
            end else begin
                if (accept) begin
                    main_d <= in_data;
                    main_v <= 1'b1;
                end else if (pop) begin
                    main_v <= 1'b0;
                end
            end
        end
    end

    pipe_stage_skid_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk         (clk),
        .reset_stages(reset_stages),
        .inc         (Stall & main_v),
        .clr         (cnt_clr),
        .cnt         (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed vector bench for pipe_stage_skid

module tb_pipe_stage_skid;

    localparam logic [31:0] RV = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset_stages, stall, flush, in_valid, out_ready, cnt_clr;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_cnt;

    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_data;
    logic [1:0]  c_occ;
    logic [15:0] c_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(32), .RESET_VAL(RV), .SKID_EN(1), .CNT_W(16)) u_skid (
        .clk(clk), .reset_stages(reset_stages), .Stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occ(a_occ), .cnt_clr(cnt_clr), .stall_cnt(a_cnt));

    pipe_stage_skid #(.WIDTH(32), .RESET_VAL(RV), .SKID_EN(1), .CNT_W(4)) u_sat (
        .clk(clk), .reset_stages(reset_stages), .Stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occ(b_occ), .cnt_clr(cnt_clr), .stall_cnt(b_cnt));

    pipe_stage_skid #(.WIDTH(32), .RESET_VAL(RV), .SKID_EN(0), .CNT_W(16)) u_noskid (
        .clk(clk), .reset_stages(reset_stages), .Stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .occ(c_occ), .cnt_clr(cnt_clr), .stall_cnt(c_cnt));

    typedef struct {
        logic        r, s, f, v;
        logic [31:0] d;
        logic        o, c;
        logic        e_ir, e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    // Inputs change at the falling edge; outputs are read 1 ns later, before the
    // rising edge consumes those inputs.
    task automatic cyc(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] d, input logic o, input logic c);
        @(negedge clk);
        reset_stages = r; stall = s; flush = f; in_valid = v;
        in_data = d; out_ready = o; cnt_clr = c;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] d, input logic o, input logic c,
                       input logic ir, input logic ov, input logic [31:0] od,
                       input logic [1:0] oc, input logic [15:0] cn);
        vec_t x;
        x.r = r; x.s = s; x.f = f; x.v = v; x.d = d; x.o = o; x.c = c;
        x.e_ir = ir; x.e_ov = ov; x.e_od = od; x.e_occ = oc; x.e_cnt = cn;
        vt.push_back(x);
    endtask

    initial begin
        //   r  s  f  v  data  o  c   ir ov od    occ cnt
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, RV,   0, 0);  // after reset
        add(0, 0, 0, 1, 1,    1, 0,  1, 0, RV,   0, 0);  // streaming
        add(0, 0, 0, 1, 2,    1, 0,  1, 1, 1,    1, 0);
        add(0, 0, 0, 1, 3,    1, 0,  1, 1, 2,    1, 0);
        add(0, 0, 0, 0, 0,    1, 0,  1, 1, 3,    1, 0);
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, 3,    0, 0);
        add(0, 0, 0, 1, 'hA,  0, 0,  1, 0, 3,    0, 0);  // backpressure
        add(0, 0, 0, 1, 'hB,  0, 0,  1, 1, 'hA,  1, 0);
        add(0, 0, 0, 1, 'hF,  0, 0,  0, 1, 'hA,  2, 0);
        add(0, 0, 0, 0, 0,    1, 0,  0, 1, 'hA,  2, 0);
        add(0, 0, 0, 0, 0,    1, 0,  1, 1, 'hB,  1, 0);
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, 'hB,  0, 0);
        add(0, 0, 0, 1, 'h55, 0, 0,  1, 0, 'hB,  0, 0);  // stall with data
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 1, 'h77, 1, 0, 0, 0, 'h55, 1, 16'(i));
        add(0, 0, 0, 0, 0,    1, 0,  1, 1, 'h55, 1, 5);
        add(0, 0, 0, 0, 0,    1, 1,  1, 0, 'h55, 0, 5);
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, 'h55, 0, 0);
        add(0, 0, 0, 1, 'hC,  0, 0,  1, 0, 'h55, 0, 0);  // flush when full
        add(0, 0, 0, 1, 'hD,  0, 0,  1, 1, 'hC,  1, 0);
        add(0, 0, 1, 1, 'hE,  0, 0,  0, 1, 'hC,  2, 0);
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, 'hC,  0, 0);
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, 'hC,  0, 0);
        add(0, 0, 0, 1, 'h21, 0, 0,  1, 0, 'hC,  0, 0);  // flush with accept+pop
        add(0, 0, 1, 1, 'h22, 1, 0,  1, 1, 'h21, 1, 0);
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, 'h21, 0, 0);
        add(0, 0, 0, 1, 'h31, 0, 0,  1, 0, 'h21, 0, 0);  // flush during stall
        add(0, 1, 1, 0, 0,    1, 0,  0, 0, 'h31, 1, 0);
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, 'h31, 0, 1);
        add(0, 0, 0, 1, 'h41, 0, 0,  1, 0, 'h31, 0, 1);  // reset mid-transfer
        add(1, 0, 0, 1, 'h42, 1, 0,  1, 1, 'h41, 1, 1);
        add(0, 0, 0, 0, 0,    1, 0,  1, 0, RV,   0, 0);

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        foreach (vt[i]) begin
            cyc(vt[i].r, vt[i].s, vt[i].f, vt[i].v, vt[i].d, vt[i].o, vt[i].c);
            chk($sformatf("v%0d in_ready", i),  32'(a_in_ready),  32'(vt[i].e_ir));
            chk($sformatf("v%0d out_valid", i), 32'(a_out_valid), 32'(vt[i].e_ov));
            chk($sformatf("v%0d out_data", i),  a_out_data,       vt[i].e_od);
            chk($sformatf("v%0d occ", i),       32'(a_occ),       32'(vt[i].e_occ));
            chk($sformatf("v%0d stall_cnt", i), 32'(a_cnt),       32'(vt[i].e_cnt));
        end

        // Saturation with a 4-bit counter; the 16-bit instance keeps counting.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 'h66, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 1);
        chk("sat cnt4", 32'(b_cnt), 15);
        chk("sat cnt16", 32'(a_cnt), 20);
        chk("sat data held", b_out_data, 'h66);
        cyc(0, 1, 0, 0, 0, 1, 0);
        chk("sat clr wins", 32'(b_cnt), 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        chk("sat resume", 32'(b_cnt), 1);

        // Single-register variant: combinational in_ready and flush discard.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 0);
        chk("ns ir0", 32'(c_in_ready), 1);
        chk("ns ov0", 32'(c_out_valid), 0);
        cyc(0, 0, 0, 1, 2, 1, 0);
        chk("ns ov1", 32'(c_out_valid), 1);
        chk("ns od1", c_out_data, 1);
        cyc(0, 0, 0, 1, 3, 1, 0);
        chk("ns od2", c_out_data, 2);
        chk("ns ir2", 32'(c_in_ready), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("ns od3", c_out_data, 3);
        chk("ns ir full", 32'(c_in_ready), 0);
        cyc(0, 1, 0, 1, 'h9, 1, 0);
        chk("ns ir stall", 32'(c_in_ready), 0);
        chk("ns ov stall", 32'(c_out_valid), 0);
        cyc(0, 0, 0, 1, 'hA, 1, 0);
        chk("ns ir via ready", 32'(c_in_ready), 1);
        cyc(0, 0, 1, 1, 'hE, 1, 0);
        chk("ns od A", c_out_data, 'hA);
        chk("ns ir flush", 32'(c_in_ready), 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("ns flush ov", 32'(c_out_valid), 0);
        chk("ns flush occ", 32'(c_occ), 0);
        chk("ns flush data", c_out_data, 'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
